bcd_result_conv: RTL
====================

// Module: bcd_result_conv
// PURPOSE
//   Downstream stage of divider_seq. Captures a quotient/remainder pair on a start
//   pulse, normally wired to the divider's done output. Converts both values to
//   packed BCD with one shared sequential double-dabble engine, quotient first.
//   Also produces per-digit leading-zero masks for the 7-segment display driver.
// PARAMETERS
//   WIDTH   16  binary operand width; must match divider_seq WIDTH
//   DIGITS  5   BCD digits per result; 5 covers 0..65535 for WIDTH=16
// PORTS
//   clk        in   1           clock, rising edge
//   rst        in   1           asynchronous, active-low reset
//   start      in   1           capture q_in/r_in and begin conversion (1-cycle pulse)
//   q_in       in   WIDTH       quotient from divider
//   r_in       in   WIDTH       remainder from divider
//   busy       out  1           conversion in progress
//   done       out  1           1-cycle pulse: bcd_q/bcd_r/lz_q/lz_r just updated
//   bcd_q      out  4*DIGITS    quotient BCD, digit i = bits [4i+3:4i], digit 0 = units
//   bcd_r      out  4*DIGITS    remainder BCD, same packing
//   lz_q       out  DIGITS      bit i=1: quotient digit i and all higher digits are zero
//   lz_r       out  DIGITS      same for remainder
// BEHAVIOUR
//   Reset (rst=0, async): every output is 0, state=IDLE, internal registers are cleared.
//   This takes effect at any time, including mid-conversion; the partial result is discarded.
//   FSM: IDLE -> CONV_Q -> CONV_R -> IDLE. There is no separate done state.
//   IDLE: done<=0, busy=0. When start=1 at edge E0: latch r_in into a holding reg.
//     Load the shift reg {DIGITS*4'b0, q_in}, cnt<=WIDTH, busy<=1, state<=CONV_Q.
//   CONV_Q/CONV_R: one iteration per edge.
//     For each BCD digit field: if >=5, add 3 (4-bit, no carry out).
//     Then shift the whole {bcd,bin} register left by 1 and decrement cnt.
//   The last iteration of CONV_Q is at edge E16 for WIDTH=16.
//     That edge stores the BCD field into shadow reg, loads the remainder and sets cnt<=WIDTH.
//   The last iteration of CONV_R is at edge E32.
//     That edge updates bcd_q, bcd_r, lz_q and lz_r together and sets done<=1.
//     It also sets busy<=0 and state<=IDLE.
//   Latency: done is high in the cycle following edge E0+2*WIDTH (32 cycles for WIDTH=16).
//   Outputs are held stable between done pulses; intermediate values are never visible.
//   start while busy=1 is ignored; q_in/r_in changes during conversion have no effect.
//   start=1 in the cycle done=1 is accepted (FSM is IDLE). This gives back-to-back operation.
//   lz masks: bit 0 is always 0, so the units digit is never blanked.
//     Value 0 gives lz = {DIGITS-1{1'b1},1'b0}.
//   Arithmetic: the correction is applied before the shift, never after the final shift.
//     With DIGITS sufficient for WIDTH, no digit overflows; the MSB bits shifted out are dropped.
// TESTING
//   q=12345, r=6789 pulse start -> done exactly 32 cycles later.
//     Expect bcd_q=20'h12345, bcd_r=20'h06789, lz_q=5'b00000, lz_r=5'b10000.
//   q=65535, r=0 -> bcd_q=20'h65535, bcd_r=20'h00000, lz_r=5'b11110.
//   q=7, r=0 -> bcd_q=20'h00007, lz_q=5'b11110. Checks small values and that no add-3 leaks.
//   start again at cycle 10 of a conversion with different q_in -> ignored.
//     The result matches the first operands and done still occurs at cycle 32.
//   rst low at cycle 20 of a conversion -> outputs and busy are 0 immediately.
//     No done pulse follows; the next start converts correctly.
//   Start asserted in the done cycle (back-to-back) -> second conversion is accepted.
//     Its done follows 32 cycles later and the first result holds until then.
//   Random: 1000 pairs checked against a decimal reference model.

Source files
------------

// File: rtl/bcd_result_conv_if.sv
// Handshake/result bundle between the divider-side producer and bcd_result_conv.
// master drives operands and start; slave (the converter) returns status and BCD results.
interface bcd_result_conv_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      q_in;
  logic [WIDTH-1:0]      r_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_q;
  logic [4*DIGITS-1:0]   bcd_r;
  logic [DIGITS-1:0]     lz_q;
  logic [DIGITS-1:0]     lz_r;

  modport master (
    output start, q_in, r_in,
    input  busy, done, bcd_q, bcd_r, lz_q, lz_r
  );

  modport slave (
    input  start, q_in, r_in,
    output busy, done, bcd_q, bcd_r, lz_q, lz_r
  );
endinterface

// File: rtl/bcd_result_conv.sv
// Converts a captured quotient/remainder pair to packed BCD with one shared
// sequential double-dabble engine (quotient first) and builds leading-zero masks.
module bcd_result_conv #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic              clk,
  input  logic              rst,
  bcd_result_conv_if.slave  bus
);
  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CONV_Q, CONV_R} state_t;

  state_t          state_q;
  logic [SW-1:0]   shift_q;
  logic [CW-1:0]   cnt_q;
  logic [WIDTH-1:0] r_hold_q;
  logic [BW-1:0]   shadow_q;
  logic            busy_q;
  logic            done_q;
  logic [BW-1:0]   qbcd_q;
  logic [BW-1:0]   rbcd_q;
  logic [DIGITS-1:0] qlz_q;
  logic [DIGITS-1:0] rlz_q;

  logic [SW-1:0]   adj_d;
  logic [SW-1:0]   shift_d;
  logic [BW-1:0]   bcd_d;
  logic [DIGITS-1:0] lz_shadow_d;
  logic [DIGITS-1:0] lz_bcd_d;
  logic            last_d;

  // Add-3 correction on every digit field, then the whole register shifts left.
  assign adj_d[WIDTH-1:0] = shift_q[WIDTH-1:0];
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
      logic [3:0] dig;
      assign dig = shift_q[WIDTH+4*gi +: 4];
      assign adj_d[WIDTH+4*gi +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
    end
  endgenerate

  assign shift_d = adj_d << 1;
  assign bcd_d   = shift_d[SW-1:WIDTH];
  assign last_d  = (cnt_q == CW'(1));

  // Units digit is never blanked; higher bit i set when digits i..top are all zero.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
      if (gi == 0) begin : g_unit
        assign lz_shadow_d[gi] = 1'b0;
        assign lz_bcd_d[gi]    = 1'b0;
      end else begin : g_high
        assign lz_shadow_d[gi] = (shadow_q[BW-1:4*gi] == '0);
        assign lz_bcd_d[gi]    = (bcd_d[BW-1:4*gi] == '0);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      r_hold_q <= '0;
      shadow_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      qbcd_q   <= '0;
      rbcd_q   <= '0;
      qlz_q    <= '0;
      rlz_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            r_hold_q <= bus.r_in;
            shift_q  <= {{BW{1'b0}}, bus.q_in};
            cnt_q    <= CW'(WIDTH);
            busy_q   <= 1'b1;
            state_q  <= CONV_Q;
          end
        end
        CONV_Q: begin
          if (last_d) begin
            shadow_q <= bcd_d;
            shift_q  <= {{BW{1'b0}}, r_hold_q};
            cnt_q    <= CW'(WIDTH);
            state_q  <= CONV_R;
          end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_q - CW'(1);
          end
        end
        CONV_R: begin
          if (last_d) begin
            // All four outputs change together so no partial result is ever visible.
            qbcd_q  <= shadow_q;
            rbcd_q  <= bcd_d;
            qlz_q   <= lz_shadow_d;
            rlz_q   <= lz_bcd_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            shift_q <= '0;
            state_q <= IDLE;
          end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.bcd_q = qbcd_q;
  assign bus.bcd_r = rbcd_q;
  assign bus.lz_q  = qlz_q;
  assign bus.lz_r  = rlz_q;
endmodule
